// File: rtl/pong_pkg.sv
// Shared pong constants and types for the ball renderer.
// Provides the screen limits, the colour type and the renderer state enum.
package pong_pkg;

   localparam int X_MAX = 319;
   localparam int Y_MAX = 239;

   typedef logic [2:0] colour_t;

   typedef enum logic [1:0] {
      CLEAR,
      IDLE,
      ERASE,
      DRAW
   } render_state_t;

endpackage

// File: rtl/raster_counter.sv
// 2D column/row counter that walks (0,0)..(W_MAX,H_MAX) in row-major order.
// Ports: clk, reset (sync, active-low), start (zero), step (advance),
//        col/row (current position), last (at (W_MAX,H_MAX)).
module raster_counter #(
   parameter int W_MAX = 319,
   parameter int H_MAX = 239,
   parameter int CW    = 9,
   parameter int RW    = 8
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   input  logic          step,
   output logic [CW-1:0] col,
   output logic [RW-1:0] row,
   output logic          last
);

   logic [CW-1:0] col_q, col_d;
   logic [RW-1:0] row_q, row_d;
   logic          col_end;
   logic          row_end;

   assign col_end = (col_q == CW'(W_MAX));
   assign row_end = (row_q == RW'(H_MAX));
   assign col     = col_q;
   assign row     = row_q;
   assign last    = col_end && row_end;

   // Stepping past the last position wraps to (0,0), ready for the next walk.
   always_comb begin
      col_d = col_q;
      row_d = row_q;
      if (start) begin
         col_d = '0;
         row_d = '0;
      end else if (step) begin
         if (col_end) begin
            col_d = '0;
            row_d = row_end ? '0 : row_q + 1'b1;
         end else begin
            col_d = col_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         col_q <= '0;
         row_q <= '0;
      end else begin
         col_q <= col_d;
         row_q <= row_d;
      end
   end

endmodule

// File: rtl/ball_renderer.sv
// Turns ball (x,y) updates into erase/draw pixel plot commands for VGA.
// Ports: clk, reset (sync, active-low), update/x/y (from physics), ready,
//        plot/vga_x/vga_y/colour (registered pixel command to the adapter).
module ball_renderer
   import pong_pkg::*;
#(
   parameter int      BALL_SIZE      = 4,
   parameter int      X_MAX          = pong_pkg::X_MAX,
   parameter int      Y_MAX          = pong_pkg::Y_MAX,
   parameter colour_t BALL_COLOUR    = 3'b111,
   parameter colour_t BG_COLOUR      = 3'b000,
   parameter bit      CLEAR_ON_RESET = 1'b1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       update,
   input  logic [8:0] x,
   input  logic [7:0] y,
   output logic       ready,
   output logic       plot,
   output logic [8:0] vga_x,
   output logic [7:0] vga_y,
   output logic [2:0] colour
);

   render_state_t state_q, state_d;
   logic [8:0]    old_x_q, old_x_d, new_x_q, new_x_d;
   logic [7:0]    old_y_q, old_y_d, new_y_q, new_y_d;
   logic          have_prev_q, have_prev_d;
   logic          plot_q, plot_d;
   logic [8:0]    vga_x_q, vga_x_d;
   logic [7:0]    vga_y_q, vga_y_d;
   colour_t       colour_q, colour_d;

   logic [8:0] clr_col;
   logic [7:0] clr_row;
   logic       clr_last;
   logic [3:0] b_col;
   logic [3:0] b_row;
   logic       b_last;

   raster_counter #(
      .W_MAX(X_MAX), .H_MAX(Y_MAX), .CW(9), .RW(8)
   ) u_clear (
      .clk  (clk),
      .reset(reset),
      .start(1'b0),
      .step (state_q == CLEAR),
      .col  (clr_col),
      .row  (clr_row),
      .last (clr_last)
   );

   raster_counter #(
      .W_MAX(BALL_SIZE - 1), .H_MAX(BALL_SIZE - 1), .CW(4), .RW(4)
   ) u_ball (
      .clk  (clk),
      .reset(reset),
      .start(state_q == IDLE),
      .step ((state_q == ERASE) || (state_q == DRAW)),
      .col  (b_col),
      .row  (b_row),
      .last (b_last)
   );

   // Sums are one bit wider than the screen so an off-screen pixel
   // is clipped rather than wrapping back onto column/row 0.
   logic [8:0] base_x;
   logic [7:0] base_y;
   logic [9:0] sum_x;
   logic [8:0] sum_y;
   logic       on_screen;

   assign base_x    = (state_q == ERASE) ? old_x_q : new_x_q;
   assign base_y    = (state_q == ERASE) ? old_y_q : new_y_q;
   assign sum_x     = {1'b0, base_x} + {6'd0, b_col};
   assign sum_y     = {1'b0, base_y} + {5'd0, b_row};
   assign on_screen = (sum_x <= 10'(X_MAX)) && (sum_y <= 9'(Y_MAX));

   always_comb begin
      state_d     = state_q;
      old_x_d     = old_x_q;
      old_y_d     = old_y_q;
      new_x_d     = new_x_q;
      new_y_d     = new_y_q;
      have_prev_d = have_prev_q;
      plot_d      = 1'b0;
      vga_x_d     = vga_x_q;
      vga_y_d     = vga_y_q;
      colour_d    = colour_q;
      case (state_q)
         CLEAR: begin
            plot_d   = 1'b1;
            vga_x_d  = clr_col;
            vga_y_d  = clr_row;
            colour_d = BG_COLOUR;
            if (clr_last) state_d = IDLE;
         end
         IDLE: begin
            if (update) begin
               new_x_d = x;
               new_y_d = y;
               state_d = have_prev_q ? ERASE : DRAW;
            end
         end
         ERASE: begin
            plot_d   = on_screen;
            vga_x_d  = sum_x[8:0];
            vga_y_d  = sum_y[7:0];
            colour_d = BG_COLOUR;
            if (b_last) state_d = DRAW;
         end
         DRAW: begin
            plot_d   = on_screen;
            vga_x_d  = sum_x[8:0];
            vga_y_d  = sum_y[7:0];
            colour_d = BALL_COLOUR;
            if (b_last) begin
               old_x_d     = new_x_q;
               old_y_d     = new_y_q;
               have_prev_d = 1'b1;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q     <= CLEAR_ON_RESET ? CLEAR : IDLE;
         old_x_q     <= '0;
         old_y_q     <= '0;
         new_x_q     <= '0;
         new_y_q     <= '0;
         have_prev_q <= 1'b0;
         plot_q      <= 1'b0;
         vga_x_q     <= '0;
         vga_y_q     <= '0;
         colour_q    <= BG_COLOUR;
      end else begin
         state_q     <= state_d;
         old_x_q     <= old_x_d;
         old_y_q     <= old_y_d;
         new_x_q     <= new_x_d;
         new_y_q     <= new_y_d;
         have_prev_q <= have_prev_d;
         plot_q      <= plot_d;
         vga_x_q     <= vga_x_d;
         vga_y_q     <= vga_y_d;
         colour_q    <= colour_d;
      end
   end

   assign ready  = (state_q == IDLE);
   assign plot   = plot_q;
   assign vga_x  = vga_x_q;
   assign vga_y  = vga_y_q;
   assign colour = colour_q;

endmodule
